// File: rtl/sync_fifo_flex_pkg.sv
// sync_fifo_flex_pkg: shared sizing helpers and configuration checks for sync_fifo_flex
package sync_fifo_flex_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit cfg_ok(input int depth, input int af_th, input int ae_th);
    return depth >= 2 && (depth & (depth - 1)) == 0 && ae_th < af_th && af_th <= depth;
  endfunction
endpackage

// File: rtl/fifo_mem_regs.sv
// fifo_mem_regs: register file with one synchronous write port and one asynchronous read port
module fifo_mem_regs #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised synchronous FIFO with FWFT option, threshold flags, count and sticky errors
module sync_fifo_flex import sync_fifo_flex_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter bit FWFT = 1'b0,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      io_write,
  input  logic                      io_read,
  input  logic                      io_clear,
  input  logic [DATA_WIDTH-1:0]     io_din,
  output logic [DATA_WIDTH-1:0]     io_dout,
  output logic                      io_full,
  output logic                      io_empty,
  output logic                      io_almost_full,
  output logic                      io_almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   io_count,
  output logic                      io_overflow,
  output logic                      io_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C = CW'(AE_TH);
  if (!cfg_ok(DEPTH, AF_TH, AE_TH)) begin : g_bad_cfg
    $error("sync_fifo_flex: DEPTH must be a power of two >= 2 and AE_TH < AF_TH <= DEPTH");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DATA_WIDTH-1:0] rd_data, dout_q;
  logic rd_ok, wr_ok, overflow, underflow;
  assign io_count = count;
  assign io_empty = count == '0;
  assign io_full = count == FULL_C;
  assign io_almost_full = count >= AF_C;
  assign io_almost_empty = count <= AE_C;
  assign io_overflow = overflow;
  assign io_underflow = underflow;
  // clear suppresses both accepts so memory and pointers see no traffic that cycle
  assign rd_ok = io_read && !io_empty && !io_clear;
  assign wr_ok = io_write && (!io_full || rd_ok) && !io_clear;
  // FWFT output is forced to zero while empty so it stays stable and matches the reset value
  assign io_dout = FWFT ? (io_empty ? '0 : rd_data) : dout_q;
  fifo_mem_regs #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(wr_ok), .waddr(wr_ptr), .wdata(io_din), .raddr(rd_ptr), .rdata(rd_data)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      dout_q <= '0;
    end else if (io_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout_q <= rd_data;
      end
      if (wr_ok != rd_ok) count <= wr_ok ? count + CW'(1) : count - CW'(1);
      if (io_write && !wr_ok) overflow <= 1'b1;
      if (io_read && !rd_ok) underflow <= 1'b1;
    end
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed bench driving a standard and an FWFT instance with shared stimulus
module tb_sync_fifo_flex;
  logic clk = 1'b0, reset = 1'b0;
  logic io_write = 1'b0, io_read = 1'b0, io_clear = 1'b0;
  logic [7:0] io_din = '0;
  logic [7:0] d0, d1;
  logic [4:0] c0, c1;
  logic f0, e0, af0, ae0, ov0, un0;
  logic f1, e1, af1, ae1, ov1, un1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0), .AF_TH(14), .AE_TH(2)) u_std (
    .clk(clk), .reset(reset), .io_write(io_write), .io_read(io_read), .io_clear(io_clear),
    .io_din(io_din), .io_dout(d0), .io_full(f0), .io_empty(e0), .io_almost_full(af0),
    .io_almost_empty(ae0), .io_count(c0), .io_overflow(ov0), .io_underflow(un0)
  );
  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1), .AF_TH(14), .AE_TH(2)) u_fwft (
    .clk(clk), .reset(reset), .io_write(io_write), .io_read(io_read), .io_clear(io_clear),
    .io_din(io_din), .io_dout(d1), .io_full(f1), .io_empty(e1), .io_almost_full(af1),
    .io_almost_empty(ae1), .io_count(c1), .io_overflow(ov1), .io_underflow(un1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected flag vector {count, empty, full, almost_empty, almost_full, overflow, underflow}
  task automatic flags(input string tag, input int cnt, input logic ov, input logic un);
    logic [10:0] e;
    e = {cnt[4:0], cnt == 0, cnt == 16, cnt <= 2, cnt >= 14, ov, un};
    chk({tag, "_std"}, 32'({c0, e0, f0, ae0, af0, ov0, un0}), 32'(e));
    chk({tag, "_fwft"}, 32'({c1, e1, f1, ae1, af1, ov1, un1}), 32'(e));
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    io_write = w;
    io_read = r;
    io_clear = c;
    io_din = d;
    @(posedge clk);
    #1;
    io_write = 1'b0;
    io_read = 1'b0;
    io_clear = 1'b0;
  endtask

  initial begin
    #2;
    flags("reset", 0, 1'b0, 1'b0);
    chk("reset_dout_std", 32'(d0), 32'h0);
    chk("reset_dout_fwft", 32'(d1), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      flags($sformatf("fill%0d", i), i + 1, 1'b0, 1'b0);
      chk($sformatf("fill%0d_head_fwft", i), 32'(d1), 32'h00);
    end
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    flags("overflow", 16, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h10);
    flags("full_rw", 16, 1'b1, 1'b0);
    chk("full_rw_dout_std", 32'(d0), 32'h00);
    chk("full_rw_dout_fwft", 32'(d1), 32'h01);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_pre_fwft", k), 32'(d1), 32'(k < 15 ? k + 1 : 16));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("drain%0d_std", k), 32'(d0), 32'(k < 15 ? k + 1 : 16));
      flags($sformatf("drain%0d", k), 15 - k, 1'b1, 1'b0);
    end
    chk("drained_dout_fwft", 32'(d1), 32'h0);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    flags("underflow", 1, 1'b1, 1'b1);
    chk("underflow_dout_std", 32'(d0), 32'h10);
    chk("underflow_dout_fwft", 32'(d1), 32'h55);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("uf_read_dout_std", 32'(d0), 32'h55);
    flags("uf_read", 0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    flags("pre_clear", 9, 1'b1, 1'b1);
    chk("pre_clear_dout_fwft", 32'(d1), 32'h60);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    flags("clear", 0, 1'b0, 1'b0);
    chk("clear_dout_std", 32'(d0), 32'h55);
    chk("clear_dout_fwft", 32'(d1), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    chk("wrap_head_fwft", 32'(d1), 32'h0);
    for (int j = 0; j < 40; j++) begin
      chk($sformatf("wrap%0d_pre_fwft", j), 32'(d1), 32'(j));
      step(1'b1, 1'b1, 1'b0, 8'(j + 8));
      chk($sformatf("wrap%0d_std", j), 32'(d0), 32'(j));
    end
    flags("wrap", 8, 1'b0, 1'b0);
    for (int j = 40; j < 48; j++) begin
      chk($sformatf("wdrain%0d_pre_fwft", j), 32'(d1), 32'(j));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("wdrain%0d_std", j), 32'(d0), 32'(j));
    end
    flags("wrap_end", 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_rst_dout_std", 32'(d0), 32'h30);
    flags("pre_rst", 5, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    flags("mid_rst", 0, 1'b0, 1'b0);
    chk("mid_rst_dout_std", 32'(d0), 32'h0);
    chk("mid_rst_dout_fwft", 32'(d1), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h99);
    flags("post_rst_wr", 1, 1'b0, 1'b0);
    chk("post_rst_dout_fwft", 32'(d1), 32'h99);
    chk("post_rst_hold_std", 32'(d0), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_rst_rd_std", 32'(d0), 32'h99);
    flags("post_rst_rd", 0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
